// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus port between instruction fetch and data load/store.
// Data has priority, bounded by a starvation counter; one transaction outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imem_req,
    input  logic [XLEN-1:0]   imem_addr,
    input  logic              imem_kill,
    output logic [XLEN-1:0]   imem_rdata,
    output logic              imem_ready,

    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              dmem_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q;
    logic              owner_q;
    logic              kill_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic [XLEN-1:0]   imem_rdata_q;
    logic [XLEN-1:0]   dmem_rdata_q;
    logic              imem_ready_q;
    logic              dmem_ready_q;
    logic              sel_data;
    logic              grant;

    always_comb begin
        sel_data  = dmem_req & (~imem_req | (starve_q != LIMIT));
        mem_req   = (state_q == IDLE) & (imem_req | dmem_req);
        mem_we    = sel_data & dmem_we;
        mem_addr  = sel_data ? dmem_addr : imem_addr;
        mem_wdata = sel_data ? dmem_wdata : '0;
        mem_be    = sel_data ? dmem_be : '0;
        grant     = mem_req & mem_gnt;
    end

    // Fetch not waiting clears the count in any state; grants only move it in IDLE.
    always_comb begin
        starve_d = starve_q;
        if (!imem_req) begin
            starve_d = '0;
        end else if (grant) begin
            if (!sel_data) begin
                starve_d = '0;
            end else if (starve_q != LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            kill_q       <= 1'b0;
            starve_q     <= '0;
            imem_rdata_q <= XLEN'(32'h0000_0013);
            dmem_rdata_q <= '0;
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
        end else begin
            imem_ready_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            starve_q     <= starve_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= sel_data;
                        kill_q  <= ~sel_data & imem_kill;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!owner_q && imem_kill) begin
                        kill_q <= 1'b1;
                    end
                    // Ready is registered here so it is high for exactly the RESP cycle.
                    if (mem_rvalid) begin
                        if (owner_q) begin
                            dmem_rdata_q <= mem_rdata;
                            dmem_ready_q <= 1'b1;
                        end else begin
                            imem_rdata_q <= mem_rdata;
                            imem_ready_q <= ~(kill_q | imem_kill);
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign imem_ready = imem_ready_q;
    assign dmem_ready = dmem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bus responses are driven by the bench and the
// expected ready/rdata of each response is queued, then checked when a ready pulse appears.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_kill;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ready;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct packed {
        logic        data;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   s = 0;

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_kill(imem_kill),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_ready || dmem_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {30'b0, imem_ready, dmem_ready}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_imem_ready", {31'b0, imem_ready}, {31'b0, ~e.data});
                chk("resp_dmem_ready", {31'b0, dmem_ready}, {31'b0, e.data});
                chk("resp_rdata", e.data ? dmem_rdata : imem_rdata, e.rdata);
            end
        end
    end

    // Entered at an IDLE cycle with requests already driven; returns at the next IDLE cycle.
    // kmode: 0 none, 1 kill during first WAIT cycle, 2 kill in the granting IDLE cycle.
    task automatic run_txn(input int gdly, input int rdly, input logic [31:0] rd,
                           input int kmode, output logic got_data);
        logic        exp_data;
        logic [31:0] ea;
        exp_data = dmem_req && (!imem_req || s != LIM);
        ea = exp_data ? dmem_addr : imem_addr;
        #1;
        chk("req_idle", {31'b0, mem_req}, 32'd1);
        chk("cmd_addr", mem_addr, ea);
        chk("cmd_we", {31'b0, mem_we}, {31'b0, exp_data & dmem_we});
        chk("cmd_wdata", mem_wdata, exp_data ? dmem_wdata : 32'h0);
        chk("cmd_be", {28'b0, mem_be}, exp_data ? {28'b0, dmem_be} : 32'h0);
        got_data = (mem_addr == dmem_addr);
        repeat (gdly) begin
            tick();
            chk("req_hold", {31'b0, mem_req}, 32'd1);
            chk("addr_hold", mem_addr, ea);
            chk("wdata_hold", mem_wdata, exp_data ? dmem_wdata : 32'h0);
        end
        mem_gnt = 1'b1;
        if (kmode == 2) imem_kill = 1'b1;
        tick();
        gnt_cyc = cyc;
        mem_gnt = 1'b0;
        imem_kill = 1'b0;
        if (!imem_req || !exp_data) s = 0;
        else if (s < LIM) s = s + 1;
        #1;
        chk("req_wait", {31'b0, mem_req}, 32'd0);
        if (kmode == 1) begin
            imem_kill = 1'b1;
            tick();
            imem_kill = 1'b0;
            repeat (rdly - 2) tick();
        end else begin
            repeat (rdly - 1) tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        if (!(kmode != 0 && !exp_data)) sb.push_back('{exp_data, rd});
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("req_resp", {31'b0, mem_req}, 32'd0);
        tick();
        chk("rdata_hold", exp_data ? dmem_rdata : imem_rdata, rd);
    endtask

    initial begin
        logic       g;
        logic [9:0] pat;
        int         prev;

        rst = 1'b1;
        imem_req = 0; imem_addr = 0; imem_kill = 0;
        dmem_req = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0; dmem_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_imem_ready", {31'b0, imem_ready}, 32'd0);
        chk("rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'h0000_0013);
        chk("rst_dmem_rdata", dmem_rdata, 32'h0);

        // Fetch only, immediate grant, rvalid next cycle.
        imem_req = 1; imem_addr = 32'h100;
        run_txn(0, 1, 32'h0050_0093, 0, g);
        chk("fetch_owner", {31'b0, g}, 32'd0);
        imem_req = 0;

        // Store with grant delayed 3 cycles.
        dmem_req = 1; dmem_we = 1; dmem_addr = 32'h2000;
        dmem_wdata = 32'hDEAD_BEEF; dmem_be = 4'hF;
        run_txn(3, 2, 32'h0, 0, g);
        chk("store_owner", {31'b0, g}, 32'd1);
        dmem_req = 0; dmem_we = 0;
        tick();
        s = 0;

        // Starvation: both continuously requesting.
        imem_req = 1; imem_addr = 32'h400;
        dmem_req = 1; dmem_addr = 32'h3000; dmem_wdata = 32'h1234_5678; dmem_be = 4'h3;
        pat = '0;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            run_txn(0, 1, 32'hA000 + i, 0, g);
            pat[9 - i] = g;
            if (i > 0) chk("starve_gap", gnt_cyc - prev, 32'd3);
            prev = gnt_cyc;
        end
        chk("starve_order", {22'b0, pat}, {22'b0, 10'b11_1101_1110});
        imem_req = 0; dmem_req = 0;
        tick();
        s = 0;

        // Kill during WAIT, then a normal fetch, then kill in the grant cycle.
        imem_req = 1; imem_addr = 32'h700;
        run_txn(0, 3, 32'h1111_2222, 1, g);
        imem_addr = 32'h704;
        run_txn(0, 1, 32'h3333_4444, 0, g);
        chk("after_kill_owner", {31'b0, g}, 32'd0);
        imem_addr = 32'h708;
        run_txn(1, 2, 32'h5555_6666, 2, g);
        imem_req = 0;
        // Kill has no effect on a data transaction.
        dmem_req = 1; dmem_we = 0; dmem_addr = 32'h4000;
        run_txn(0, 3, 32'h7777_8888, 1, g);
        dmem_req = 0;
        tick();
        s = 0;

        // Back-to-back: data then fetch on a single-cycle bus.
        imem_req = 1; imem_addr = 32'h600;
        dmem_req = 1; dmem_addr = 32'h5000;
        run_txn(0, 1, 32'hCAFE_0001, 0, g);
        chk("b2b_first", {31'b0, g}, 32'd1);
        prev = gnt_cyc;
        dmem_req = 0;
        run_txn(0, 1, 32'hCAFE_0002, 0, g);
        chk("b2b_second", {31'b0, g}, 32'd0);
        chk("b2b_gap", gnt_cyc - prev, 32'd3);
        imem_req = 0;
        tick();
        s = 0;

        // Reset in WAIT, then a stray rvalid.
        imem_req = 1; imem_addr = 32'h800;
        mem_gnt = 1;
        tick();
        mem_gnt = 0; imem_req = 0;
        rst = 1;
        tick();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 0;
        tick();
        tick();
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_imem_ready", {31'b0, imem_ready}, 32'd0);
        chk("mid_rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("mid_rst_imem_rdata", imem_rdata, 32'h0000_0013);
        chk("mid_rst_dmem_rdata", dmem_rdata, 32'h0);
        s = 0;
        // Arbiter must be back in IDLE and serve a new request.
        imem_req = 1; imem_addr = 32'h900;
        run_txn(0, 1, 32'h0000_AB00, 0, g);
        imem_req = 0;
        tick();
        tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
